// File: rtl/image_proc_pkg.sv
// Shared types for the image_processor arbiter slice: window layout, kernel
// select encoding and arbiter FSM states.
package image_proc_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_DIM = 3;
  localparam int WIN_W   = WIN_DIM * WIN_DIM * PIX_W;
  localparam int RES_W   = 16;

  // pixel[i][j] lands at bits (i*3+j)*8 +: 8
  typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] window_t;

  typedef enum logic [1:0] {CFG_K0, CFG_K1, CFG_K2, CFG_K3} cfg_e;

  typedef enum logic {IDLE, ISSUE} arb_state_e;

endpackage

// File: rtl/image_proc_tag_fifo.sv
// In-order id FIFO: remembers which requester owns each window in flight.
module image_proc_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot being written, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/image_proc_arbiter.sv
// Round-robin front end sharing one image_processor among NUM_REQ producers.
// Define IP_ARB_TIMEOUT_EN to add the result watchdog and timeout_err port.
module image_proc_arbiter
  import image_proc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TAG_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_config,
  input  logic [WIN_W*NUM_REQ-1:0]       req_window,
  output logic [1:0]                     ip_config_select,
  output logic [WIN_W-1:0]               ip_input_data,
  output logic                           ip_input_valid,
  input  logic                           ip_input_ready,
  input  logic [RES_W-1:0]               ip_output_data,
  input  logic                           ip_output_valid,
  output logic                           ip_output_ready,
  output logic [RES_W-1:0]               rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(TAG_DEPTH):0]     outstanding,
  output logic                           orphan_err
`ifdef IP_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TAG_DEPTH < 2 ||
      (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("image_proc_arbiter: illegal parameter set");
  end

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr, winner, id_q, head_id;
  logic            found, grant, push, pop, flush;
  logic            fifo_full, fifo_empty;
  window_t         win_q;
  cfg_e            cfg_q;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      automatic int k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[k]) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end

  // no issue is pending while IDLE, so FIFO occupancy alone bounds the grant
  assign grant = !rst && (state == IDLE) && found && !fifo_full;
  assign push  = (state == ISSUE) && ip_input_ready && !flush;
  assign pop   = !fifo_empty && ip_output_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (ip_input_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    req_ready      = '0;
    ip_input_valid = 1'b0;
    if (grant) req_ready[winner] = 1'b1;
    if (state == ISSUE) ip_input_valid = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      win_q  <= '0;
      cfg_q  <= CFG_K0;
      id_q   <= '0;
    end else if (grant) begin
      win_q  <= req_window[winner*WIN_W +: WIN_W];
      cfg_q  <= cfg_e'(req_config[2*winner +: 2]);
      id_q   <= winner;
      rr_ptr <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

  assign ip_input_data    = win_q;
  assign ip_config_select = cfg_q;

  image_proc_tag_fifo #(.DEPTH(TAG_DEPTH), .W(ID_W)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (id_q),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // with no tag to route to, results are swallowed rather than stalling the IP
  always_comb begin
    rsp_valid       = !fifo_empty && ip_output_valid;
    rsp_data        = fifo_empty ? '0 : ip_output_data;
    rsp_id          = fifo_empty ? '0 : head_id;
    ip_output_ready = !rst && (fifo_empty || rsp_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              orphan_err <= 1'b0;
    else if (fifo_empty && ip_output_valid) orphan_err <= 1'b1;
  end

`ifdef IP_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign flush = !fifo_empty && !pop && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (fifo_empty || pop || flush) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;
      if (flush) timeout_err <= 1'b1;
    end
  end
`else
  assign flush = 1'b0;
`endif

endmodule

// File: tb/tb_image_proc_arbiter.sv
// Directed plus random checks of image_proc_arbiter against a transaction-level
// model (grant queue of ids, rr index, in-flight window).
module tb_image_proc_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 4;
  localparam int TMO       = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [2*NUM_REQ-1:0]    req_config;
  logic [72*NUM_REQ-1:0]   req_window;
  logic [1:0]              ip_config_select;
  logic [71:0]             ip_input_data;
  logic                    ip_input_valid;
  logic                    ip_input_ready;
  logic [15:0]             ip_output_data;
  logic                    ip_output_valid;
  logic                    ip_output_ready;
  logic [15:0]             rsp_data;
  logic [1:0]              rsp_id;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [2:0]              outstanding;
  logic                    orphan_err;
`ifdef IP_ARB_TIMEOUT_EN
  logic                    timeout_err;
`endif

  image_proc_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_config       (req_config),
    .req_window       (req_window),
    .ip_config_select (ip_config_select),
    .ip_input_data    (ip_input_data),
    .ip_input_valid   (ip_input_valid),
    .ip_input_ready   (ip_input_ready),
    .ip_output_data   (ip_output_data),
    .ip_output_valid  (ip_output_valid),
    .ip_output_ready  (ip_output_ready),
    .rsp_data         (rsp_data),
    .rsp_id           (rsp_id),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .outstanding      (outstanding),
    .orphan_err       (orphan_err)
`ifdef IP_ARB_TIMEOUT_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_busy;
  logic [71:0] m_win;
  logic [1:0]  m_cfg;
  int          m_id;
  int          m_rr;
  int          m_q[$];
  bit          m_orphan;
  int          m_tmo;
  bit          m_terr;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_win = '0; m_cfg = '0; m_id = 0; m_rr = 0;
    m_q.delete(); m_orphan = 0; m_tmo = 0; m_terr = 0;
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", req_ready, '0);
    chk("rst_in_valid", ip_input_valid, 0);
    chk("rst_in_data", ip_input_data, '0);
    chk("rst_cfg", ip_config_select, '0);
    chk("rst_out_ready", ip_output_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_outstanding", outstanding, '0);
    chk("rst_orphan", orphan_err, 0);
`ifdef IP_ARB_TIMEOUT_EN
    chk("rst_timeout", timeout_err, 0);
`endif
  endtask

  // Check one cycle against the model with the inputs currently driven, then
  // advance the model and the clock. Entered and left at posedge+1.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int  win;
    bit  pop, push, hit;
    #1;
    exp_rdy = '0;
    win = -1;
    if (!m_busy && m_q.size() < TAG_DEPTH)
      for (int i = 0; i < NUM_REQ; i++) begin
        automatic int k = (m_rr + i) % NUM_REQ;
        if (win < 0 && req_valid[k]) win = k;
      end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("in_valid", ip_input_valid, m_busy);
    if (m_busy) begin
      chk("in_data", ip_input_data, m_win);
      chk("in_cfg", ip_config_select, m_cfg);
    end
    if (m_q.size() > 0) begin
      chk("rsp_valid", rsp_valid, ip_output_valid);
      chk("out_ready", ip_output_ready, rsp_ready);
      if (ip_output_valid) begin
        chk("rsp_id", rsp_id, m_q[0]);
        chk("rsp_data", rsp_data, ip_output_data);
      end
    end else begin
      chk("rsp_valid_empty", rsp_valid, 0);
      chk("out_ready_empty", ip_output_ready, 1);
    end
    chk("outstanding", outstanding, m_q.size());
    chk("orphan_err", orphan_err, m_orphan);
`ifdef IP_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, m_terr);
`endif
    pop  = (m_q.size() > 0) && ip_output_valid && rsp_ready;
    push = m_busy && ip_input_ready;
    hit  = 0;
`ifdef IP_ARB_TIMEOUT_EN
    hit = (m_q.size() > 0) && !pop && (m_tmo == TMO - 1);
    if (hit || pop || m_q.size() == 0) m_tmo = 0;
    else m_tmo++;
`endif
    if (m_q.size() == 0 && ip_output_valid) m_orphan = 1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!hit) m_q.push_back(m_id);
      m_busy = 0;
    end
    if (win >= 0) begin
      m_busy = 1;
      m_win  = req_window[win*72 +: 72];
      m_cfg  = req_config[2*win +: 2];
      m_id   = win;
      m_rr   = (win + 1) % NUM_REQ;
    end
    if (hit) begin
      m_q.delete();
      m_busy = 0;
      m_terr = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [71:0] exp_win;
    int gcnt[NUM_REQ];

    rst = 1'b1;
    req_valid = '0; req_config = '0; req_window = '0;
    ip_input_ready = 1'b0; ip_output_data = '0; ip_output_valid = 1'b0; rsp_ready = 1'b0;
    model_reset();
    #3;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request from requester 2
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        exp_win[(i*3+j)*8 +: 8]                = 8'((i*3+j+1)*10);
        req_window[2*72 + (i*3+j)*8 +: 8]      = 8'((i*3+j+1)*10);
      end
    req_config[5:4] = 2'd1;
    req_valid = 4'b0100; ip_input_ready = 1'b1; rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    #1;
    chk("single_valid", ip_input_valid, 1);
    chk("single_data", ip_input_data, exp_win);
    chk("single_cfg", ip_config_select, 2'd1);
    cycle();
    cycle();
    ip_output_valid = 1'b1; ip_output_data = 16'h0123;
    #1;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 16'h0123);
    cycle();
    ip_output_valid = 1'b0;
    cycle();

    // round robin: all requesters valid, results returned promptly
    for (int k = 0; k < NUM_REQ; k++) gcnt[k] = 0;
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      ip_output_valid = (m_q.size() > 0);
      ip_output_data  = 16'($urandom());
      #1;
      for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) gcnt[k]++;
      cycle();
    end
    for (int k = 0; k < NUM_REQ; k++) chk("rr_share", gcnt[k], 2);
    ip_output_valid = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      ip_output_valid = (m_q.size() > 0);
      cycle();
    end
    ip_output_valid = 1'b0;

    // input backpressure during ISSUE, then output backpressure
    req_valid = '1; ip_input_ready = 1'b0;
    cycle();
    for (int c = 0; c < 5; c++) cycle();
    ip_input_ready = 1'b1; req_valid = '0;
    cycle();
    ip_output_valid = 1'b1; ip_output_data = 16'hbeef; rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    rsp_ready = 1'b1;
    cycle();
    ip_output_valid = 1'b0;

    // fill the tag FIFO with no results returning
    req_valid = '1;
    for (int c = 0; c < 10; c++) cycle();
    #1;
    chk("full_outstanding", outstanding, 4);
    chk("full_no_grant", req_ready, '0);
    ip_output_valid = 1'b1; ip_output_data = 16'h5a5a;
    cycle();
    ip_output_valid = 1'b0;
    #1;
    chk("full_regrant", |req_ready, 1);
    cycle();
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      if (m_q.size() == 0 && !m_busy) break;
      ip_output_valid = (m_q.size() > 0);
      ip_output_data  = 16'($urandom());
      cycle();
    end
    ip_output_valid = 1'b0;
    chk("drained", outstanding, 0);

    // orphan result, then async reset in the middle of an ISSUE
    ip_output_valid = 1'b1; ip_output_data = 16'hdead;
    cycle();
    ip_output_valid = 1'b0;
    #1;
    chk("orphan_set", orphan_err, 1);
    req_valid = 4'b0001; ip_input_ready = 1'b0;
    cycle();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ip_input_ready = 1'b1;
    cycle();

`ifdef IP_ARB_TIMEOUT_EN
    // two windows issued, results never come back
    req_valid = 4'b0001; cycle();
    req_valid = '0;      cycle();
    req_valid = 4'b0010; cycle();
    req_valid = '0;      cycle();
    for (int c = 0; c < 18; c++) cycle();
    #1;
    chk("tmo_err", timeout_err, 1);
    chk("tmo_outstanding", outstanding, 0);
    chk("tmo_idle", ip_input_valid, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int w = 0; w < 9; w++) req_window[w*32 +: 32] = $urandom();
      req_config      = 8'($urandom_range(0, 255));
      ip_input_ready  = ($urandom_range(0, 3) != 0);
      ip_output_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      ip_output_data  = 16'($urandom());
      rsp_ready       = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
